crc_serial: RTL and testbench

Parametrised serial CRC engine built on the team's XOR primitive. It extends the single two-input XOR gate into a clocked, feedback-shift accumulator: one data bit per enabled clock, programmable width, polynomial and seed. It runs a message-framing state machine and reports a zero-residue check. It sits between a serial bit source and any framing/check logic that needs a CRC or a pass/fail residue.

---
 rtl/crc_serial.sv | 104 ++++++++++
 tb/tb_crc_serial.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/crc_serial.sv
// Serial MSB-first CRC engine: one bit per enabled clock, programmable width,
// polynomial and seed, with IDLE/RUN/DONE message framing and a zero-residue flag.
module crc_serial #(
    parameter int unsigned WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY = WIDTH'(8'h07),
    parameter logic [WIDTH-1:0] INIT = WIDTH'(8'h00),
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             din,
    input  logic             din_valid,
    input  logic             last,
    output logic [WIDTH-1:0] crc,
    output logic             crc_valid,
    output logic             match,
    output logic             busy,
    output logic [CNT_W-1:0] bit_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_crc;
    logic [WIDTH-1:0] w_crc_next;
    logic [WIDTH-1:0] w_crc_upd;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_fb;
    logic             r_busy;
    logic             r_crc_valid;
    logic             r_match;
    logic             w_busy_next;
    logic             w_crc_valid_next;
    logic             w_match_next;

    // One LFSR step: feedback is the outgoing MSB folded with the incoming bit.
    assign w_fb      = r_crc[WIDTH-1] ^ din;
    assign w_crc_upd = {r_crc[WIDTH-2:0], 1'b0} ^ (w_fb ? POLY : WIDTH'(0));

    // Status flags are registered from the next state so outputs never see inputs.
    always_comb begin
        w_state_next = r_state;
        w_crc_next   = r_crc;
        w_cnt_next   = r_cnt;

        if (start) begin
            w_state_next = S_RUN;
            w_crc_next   = INIT;
            w_cnt_next   = CNT_W'(0);
        end else begin
            case (r_state)
                S_RUN: begin
                    if (din_valid) begin
                        w_crc_next = w_crc_upd;
                        if (r_cnt != {CNT_W{1'b1}}) begin
                            w_cnt_next = r_cnt + CNT_W'(1);
                        end
                        if (last) begin
                            w_state_next = S_DONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        w_busy_next      = (w_state_next == S_RUN);
        w_crc_valid_next = (w_state_next == S_DONE);
        w_match_next     = (w_state_next == S_DONE) && (w_crc_next == WIDTH'(0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_crc       <= INIT;
            r_cnt       <= CNT_W'(0);
            r_busy      <= 1'b0;
            r_crc_valid <= 1'b0;
            r_match     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_crc       <= w_crc_next;
            r_cnt       <= w_cnt_next;
            r_busy      <= w_busy_next;
            r_crc_valid <= w_crc_valid_next;
            r_match     <= w_match_next;
        end
    end

    assign crc       = r_crc;
    assign crc_valid = r_crc_valid;
    assign match     = r_match;
    assign busy      = r_busy;
    assign bit_count = r_cnt;

endmodule

// File: tb/tb_crc_serial.sv
// Bench for crc_serial: three instances (CRC-8 default, CRC-16/CCITT seeded FFFF,
// 4-bit counter) share one stimulus stream; results checked against a GF(2) long-division model.
module tb_crc_serial;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        din;
    logic        din_valid;
    logic        last;

    logic [7:0]  crc8;
    logic        v8, m8, b8;
    logic [15:0] cnt8;
    logic [15:0] crc16;
    logic        v16, m16, b16;
    logic [15:0] cnt16;
    logic [7:0]  crcc;
    logic        vc, mc, bc;
    logic [3:0]  cntc;

    int n_cmp = 0;
    int n_err = 0;
    bit msg_q[$];

    crc_serial dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din), .din_valid(din_valid),
        .last(last), .crc(crc8), .crc_valid(v8), .match(m8), .busy(b8), .bit_count(cnt8)
    );

    crc_serial #(.WIDTH(16), .POLY(16'h1021), .INIT(16'hFFFF)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din), .din_valid(din_valid),
        .last(last), .crc(crc16), .crc_valid(v16), .match(m16), .busy(b16), .bit_count(cnt16)
    );

    crc_serial #(.CNT_W(4)) dutc (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din), .din_valid(din_valid),
        .last(last), .crc(crcc), .crc_valid(vc), .match(mc), .busy(bc), .bit_count(cntc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remainder of (M(x)*x^w + INIT(x)*x^L) mod G(x), by schoolbook long division.
    function automatic logic [31:0] ref_crc(input int w, input logic [31:0] poly,
                                            input logic [31:0] init);
        bit d[$];
        int len;
        logic [31:0] res;
        d = msg_q;
        len = msg_q.size();
        for (int k = 0; k < w; k++) d.push_back(1'b0);
        for (int k = 0; k < w; k++) d[k] = d[k] ^ init[w-1-k];
        for (int i = 0; i < len; i++) begin
            if (d[i]) begin
                d[i] = 1'b0;
                for (int k = 1; k <= w; k++) d[i+k] = d[i+k] ^ poly[w-k];
            end
        end
        res = '0;
        for (int k = 0; k < w; k++) res[w-1-k] = d[len+k];
        return res;
    endfunction

    function automatic int sat_cnt(input int n, input int cw);
        int mx;
        mx = (1 << cw) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) msg_q.push_back(b[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Feed msg_q MSB-first with last on the final bit; idle gaps carry random din/last.
    task automatic feed_msg(input int gap_pct);
        int n;
        n = msg_q.size();
        for (int i = 0; i < n; i++) begin
            if (int'($urandom_range(99)) < gap_pct) begin
                repeat ($urandom_range(1, 3)) begin
                    din = 1'($urandom); last = 1'($urandom); din_valid = 1'b0;
                    tick();
                end
            end
            din = msg_q[i]; din_valid = 1'b1; last = (i == n - 1);
            tick();
        end
        din_valid = 1'b0; last = 1'b0; din = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; din = 1'b0; din_valid = 1'b0; last = 1'b0;
        #12;
        n_cmp++; if (crc8 !== 8'h00)    begin n_err++; $display("FAIL reset_crc8 got %h exp 00", crc8); end
        n_cmp++; if (crc16 !== 16'hFFFF) begin n_err++; $display("FAIL reset_crc16 got %h exp ffff", crc16); end
        n_cmp++; if ({b8, v8, m8} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b exp 000", {b8, v8, m8}); end
        n_cmp++; if (cnt8 !== 16'd0)    begin n_err++; $display("FAIL reset_cnt got %0d exp 0", cnt8); end
        @(negedge clk); rst_n = 1'b1;
        tick();
        do_start();
        n_cmp++; if (b8 !== 1'b1) begin n_err++; $display("FAIL start_busy got %b exp 1", b8); end
        for (int i = 0; i < 5; i++) begin
            din = 1'($urandom); din_valid = 1'b1; last = 1'b0; tick();
        end
        din_valid = 1'b0;
        n_cmp++; if (cnt8 !== 16'd5) begin n_err++; $display("FAIL midrun_cnt got %0d exp 5", cnt8); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (crc8 !== 8'h00 || crc16 !== 16'hFFFF) begin n_err++; $display("FAIL async_reset_crc got %h/%h exp 00/ffff", crc8, crc16); end
        n_cmp++; if ({b8, v8, m8} !== 3'b000 || cnt8 !== 16'd0) begin n_err++; $display("FAIL async_reset_state got flags %b cnt %0d exp 000 0", {b8, v8, m8}, cnt8); end
        @(negedge clk); rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_byte();
        logic [7:0] bytes [2];
        logic [7:0] exp [2];
        bytes[0] = 8'h01; exp[0] = 8'h07;
        bytes[1] = 8'h80; exp[1] = 8'h89;
        for (int t = 0; t < 2; t++) begin
            msg_q.delete(); push_byte(bytes[t]);
            do_start(); feed_msg(0);
            n_cmp++; if (crc8 !== exp[t]) begin n_err++; $display("FAIL byte_crc[%h] got %h exp %h", bytes[t], crc8, exp[t]); end
            n_cmp++; if (crc8 !== 8'(ref_crc(8, 32'h07, 32'h00))) begin n_err++; $display("FAIL byte_model[%h] got %h exp %h", bytes[t], crc8, 8'(ref_crc(8, 32'h07, 32'h00))); end
            n_cmp++; if (cnt8 !== 16'd8 || {b8, v8, m8} !== 3'b010) begin n_err++; $display("FAIL byte_status[%h] got cnt %0d flags %b exp 8 010", bytes[t], cnt8, {b8, v8, m8}); end
        end
    endtask

    task automatic test_std_vector();
        msg_q.delete();
        for (int c = 0; c < 9; c++) push_byte(8'h31 + 8'(c));
        do_start(); feed_msg(0);
        n_cmp++; if (crc8 !== 8'hF4)    begin n_err++; $display("FAIL std_crc8 got %h exp f4", crc8); end
        n_cmp++; if (crc16 !== 16'h29B1) begin n_err++; $display("FAIL std_crc16 got %h exp 29b1", crc16); end
        n_cmp++; if (cnt8 !== 16'd72 || cntc !== 4'hF) begin n_err++; $display("FAIL std_cnt got %0d/%h exp 72/f", cnt8, cntc); end
        n_cmp++; if (crcc !== 8'hF4 || vc !== 1'b1) begin n_err++; $display("FAIL std_sat_crc got %h v=%b exp f4 1", crcc, vc); end
        // DONE ignores data and holds its result
        for (int i = 0; i < 4; i++) begin
            din = 1'($urandom); din_valid = 1'b1; last = 1'($urandom); tick();
        end
        din_valid = 1'b0; last = 1'b0;
        n_cmp++; if (crc8 !== 8'hF4 || cnt8 !== 16'd72 || v8 !== 1'b1) begin n_err++; $display("FAIL done_hold got %h cnt %0d v=%b exp f4 72 1", crc8, cnt8, v8); end
    endtask

    task automatic test_residue();
        int idx;
        logic [7:0] exp;
        msg_q.delete(); push_byte(8'h01); push_byte(8'h07);
        do_start(); feed_msg(0);
        n_cmp++; if (crc8 !== 8'h00 || m8 !== 1'b1) begin n_err++; $display("FAIL residue_ok got %h m=%b exp 00 1", crc8, m8); end
        idx = int'($urandom_range(15));
        msg_q[idx] = ~msg_q[idx];
        exp = 8'(ref_crc(8, 32'h07, 32'h00));
        do_start(); feed_msg(0);
        n_cmp++; if (m8 !== 1'b0 || crc8 !== exp) begin n_err++; $display("FAIL residue_flip[%0d] got %h m=%b exp %h 0", idx, crc8, m8, exp); end
    endtask

    task automatic test_gaps_priority();
        msg_q.delete(); push_byte(8'h01);
        do_start(); feed_msg(60);
        n_cmp++; if (crc8 !== 8'h07 || cnt8 !== 16'd8) begin n_err++; $display("FAIL gaps_crc got %h cnt %0d exp 07 8", crc8, cnt8); end
        do_start();
        for (int i = 0; i < 3; i++) begin
            din = 1'b1; din_valid = 1'b1; last = 1'b0; tick();
        end
        start = 1'b1; din = 1'b1; din_valid = 1'b1; last = 1'b1; tick();
        start = 1'b0; din_valid = 1'b0; last = 1'b0;
        n_cmp++; if (crc8 !== 8'h00 || cnt8 !== 16'd0 || b8 !== 1'b1 || v8 !== 1'b0) begin n_err++; $display("FAIL start_priority got %h cnt %0d b=%b v=%b exp 00 0 1 0", crc8, cnt8, b8, v8); end
        last = 1'b1; din = 1'b1; tick(); tick();
        last = 1'b0;
        n_cmp++; if (b8 !== 1'b1 || v8 !== 1'b0 || cnt8 !== 16'd0) begin n_err++; $display("FAIL last_no_valid got b=%b v=%b cnt %0d exp 1 0 0", b8, v8, cnt8); end
    endtask

    task automatic test_saturation();
        logic [7:0] e8;
        msg_q.delete();
        for (int i = 0; i < 20; i++) msg_q.push_back(1'($urandom));
        e8 = 8'(ref_crc(8, 32'h07, 32'h00));
        do_start(); feed_msg(20);
        n_cmp++; if (cntc !== 4'hF || cnt8 !== 16'd20) begin n_err++; $display("FAIL sat_cnt got %h/%0d exp f/20", cntc, cnt8); end
        n_cmp++; if (crcc !== e8) begin n_err++; $display("FAIL sat_crc got %h exp %h", crcc, e8); end
    endtask

    // Random lengths and gaps, each start issued right after DONE.
    task automatic test_back_to_back();
        logic [7:0]  e8;
        logic [15:0] e16;
        int len;
        for (int t = 0; t < 25; t++) begin
            msg_q.delete();
            len = int'($urandom_range(1, 48));
            for (int i = 0; i < len; i++) msg_q.push_back(1'($urandom));
            if (t % 5 == 4) begin
                e8 = 8'(ref_crc(8, 32'h07, 32'h00));
                for (int k = 7; k >= 0; k--) msg_q.push_back(e8[k]);
            end
            e8  = 8'(ref_crc(8, 32'h07, 32'h00));
            e16 = 16'(ref_crc(16, 32'h1021, 32'hFFFF));
            do_start(); feed_msg((t % 2) ? 30 : 0);
            n_cmp++; if (crc8 !== e8 || m8 !== (e8 == 8'h00)) begin n_err++; $display("FAIL rand8[%0d] got %h m=%b exp %h", t, crc8, m8, e8); end
            n_cmp++; if (crc16 !== e16 || v16 !== 1'b1) begin n_err++; $display("FAIL rand16[%0d] got %h v=%b exp %h", t, crc16, v16, e16); end
            n_cmp++; if (int'(cnt8) != msg_q.size() || int'(cntc) != sat_cnt(msg_q.size(), 4)) begin n_err++; $display("FAIL randcnt[%0d] got %0d/%0d exp %0d/%0d", t, cnt8, cntc, msg_q.size(), sat_cnt(msg_q.size(), 4)); end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_std_vector();
        test_residue();
        test_gaps_priority();
        test_saturation();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
